// File: rtl/trig_pulse_gen.sv
// Programmable square-wave / trigger-burst generator with edge markers.
// Optional burst counting is compiled in when TRIG_BURST_EN is defined.
module trig_pulse_gen #(
    parameter int unsigned HALF_PERIOD_DEF = 6250,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned BURST_W         = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   half_period,
    input  logic [BURST_W-1:0] burst_len,
    output logic               signal_out,
    output logic               rise_pulse,
    output logic               fall_pulse,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] H_DEF = CNT_W'(HALF_PERIOD_DEF);
    localparam logic [CNT_W-1:0] H_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_reg;
    logic [CNT_W-1:0] h_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             stop_pend_reg;
    logic             signal_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [CNT_W-1:0] h_start;
    logic             start_acc;
    logic             phase_end;
    logic             burst_last;
    logic             end_run;

    always_comb begin
        h_start = half_period;
        if (half_period == '0) begin
            h_start = H_DEF;
        end else if (half_period == ONE) begin
            h_start = H_MIN;
        end
    end

    // A simultaneous stop in IDLE suppresses the start.
    assign start_acc = (state_reg == IDLE) && start && !stop;
    assign phase_end = (cnt_reg == '0);
    assign end_run   = stop_pend_reg || stop || burst_last;

`ifdef TRIG_BURST_EN
    logic [BURST_W-1:0] n_reg;
    logic [BURST_W-1:0] per_reg;

    // per_reg counts started periods; it saturates so continuous runs never wrap.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            n_reg   <= '0;
            per_reg <= '0;
        end else if (start_acc) begin
            n_reg   <= burst_len;
            per_reg <= BURST_W'(1);
        end else if (state_reg == LOW && phase_end && !end_run && per_reg != '1) begin
            per_reg <= per_reg + BURST_W'(1);
        end
    end

    assign burst_last = (n_reg != '0) && (per_reg == n_reg);
`else
    logic burst_len_unused;
    assign burst_len_unused = ^burst_len;
    assign burst_last       = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= IDLE;
            h_reg         <= '0;
            cnt_reg       <= '0;
            stop_pend_reg <= 1'b0;
            signal_reg    <= 1'b0;
            rise_reg      <= 1'b0;
            fall_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_acc) begin
                        state_reg     <= HIGH;
                        h_reg         <= h_start;
                        cnt_reg       <= h_start - ONE;
                        stop_pend_reg <= 1'b0;
                        signal_reg    <= 1'b1;
                        rise_reg      <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                HIGH: begin
                    if (stop) begin
                        stop_pend_reg <= 1'b1;
                    end
                    if (phase_end) begin
                        state_reg  <= LOW;
                        cnt_reg    <= h_reg - ONE;
                        signal_reg <= 1'b0;
                        fall_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - ONE;
                    end
                end
                LOW: begin
                    if (stop) begin
                        stop_pend_reg <= 1'b1;
                    end
                    if (phase_end) begin
                        if (end_run) begin
                            state_reg     <= IDLE;
                            stop_pend_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            state_reg  <= HIGH;
                            cnt_reg    <= h_reg - ONE;
                            signal_reg <= 1'b1;
                            rise_reg   <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign signal_out = signal_reg;
    assign rise_pulse = rise_reg;
    assign fall_pulse = fall_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: doc/trig_pulse_gen.md
# trig_pulse_gen

Programmable square-wave and trigger-burst generator, the transmit side of the edge-check path. It produces the trigger waveform that the edge checker consumes, such as the 8 kHz test trigger derived from the 100 MHz system clock. It also emits one-cycle rise and fall markers aligned to each generated edge, so downstream logic and the bench can cross-check the detected edges against the generated ones.

## Interface
- HALF_PERIOD_DEF, 6250, default half-period in sys_clk cycles, used when `half_period` == 0 (6250 → 8 kHz at 100 MHz)
- CNT_W, 16, width of the half-period counter and of `half_period`
- BURST_W, 8, width of the burst counter and of `burst_len`

- sys_clk  in  1  system clock, 100 MHz, rising-edge
- sys_rst_n  in  1  asynchronous, active-low reset
- start  in  1  start request; sampled every cycle, acted on only in IDLE
- stop  in  1  graceful stop request; sampled every cycle
- half_period  in  CNT_W  half-period H in cycles; latched on accepted start
- burst_len  in  BURST_W  number of full periods N; 0 = continuous; latched on accepted start
- signal_out  out  1  generated waveform (registered)
- rise_pulse  out  1  one-cycle pulse, coincident with each 0→1 of `signal_out`
- fall_pulse  out  1  one-cycle pulse, coincident with each 1→0 of `signal_out`
- busy  out  1  high from the first rise until the run ends
- done  out  1  one-cycle pulse marking the end of a run

## Operation
- States:
  - IDLE: waiting for a start.
  - HIGH: `signal_out` = 1; the down-counter runs for H cycles.
  - LOW: `signal_out` = 0; the down-counter runs for H cycles.
- H resolution at start:
  - `half_period` = 0 → use HALF_PERIOD_DEF.
  - `half_period` = 1 → clamp to 2.
  - Otherwise use the input value.
  - H and N are frozen for the whole run; input changes mid-run are ignored.
- IDLE → HIGH: `start`=1 and `stop`=0. If both are high in IDLE, `stop` wins and `start` is ignored.
- HIGH → LOW: after H cycles; asserts `fall_pulse`.
- LOW → HIGH: after H cycles, when there is no pending stop and the burst is not exhausted; asserts `rise_pulse` and increments the period count.
- LOW → IDLE: after H cycles, when there is a pending stop or the completed period count equals N (N ≠ 0). Asserts `done` and deasserts `busy`; `signal_out` stays 0.
- Stop handling:
  - `stop` sets a sticky pending flag while busy.
  - The current period always completes, so no runt pulses occur.
  - A stop asserted during HIGH ends the run at the end of the following LOW phase.
- `start` while busy is ignored and has no side effects.
- Burst counter width is BURST_W; N = 2^BURST_W − 1 is the maximum burst. The counter must not wrap.

## Timing
- Reset (asynchronous, immediate, including mid-run):
  - All outputs are 0: `signal_out`, `rise_pulse`, `fall_pulse`, `busy`, `done`.
  - State → IDLE; counters and the pending-stop flag are cleared.
- Release of reset takes effect at the next sys_clk rising edge.
- Accepted start sampled at edge t: at t, `signal_out`=1, `rise_pulse`=1, `busy`=1. Start-to-output latency is 1 cycle.
- Edge positions for run-start edge t:
  - Falls at t+H, t+3H, …
  - Rises at t+2H, t+4H, …
  - Period = 2H cycles, duty exactly 50 %.
- Burst of N: the last fall is at t+(2N−1)H. At edge t+2NH: `done`=1 for one cycle and `busy`=0.
- Next start: earliest accepted start is sampled at edge t+2NH+1, one cycle after the `done` edge.

## Configuration
- TRIG_BURST_EN defined:
  - Burst counter present.
  - `burst_len` honoured as above.
- TRIG_BURST_EN undefined:
  - Burst counter removed.
  - `burst_len` port kept but ignored; every run is continuous.
  - A run ends only via `stop`, and `done` still pulses at that end.

## Test plan
- Continuous default (`half_period`=0, `burst_len`=0) → H=6250: `signal_out` period 12500 cycles (125 µs), 6250 high / 6250 low, one `rise_pulse` and one `fall_pulse` per period.
- Burst (H=4, N=3, TRIG_BURST_EN) → exactly 3 `rise_pulse` and 3 `fall_pulse`; `done` at start-edge+24 cycles; `busy` high for cycles 0–23.
- Stop during HIGH (H=10, continuous, `stop` at cycle 3) → fall at 10; `done` and IDLE at 20; no further rises.
- `start` re-asserted while busy and `half_period` changed mid-run → waveform unchanged; no extra `rise_pulse`.
- Clamp: `half_period`=1 → H=2, period 4 cycles.
- `sys_rst_n` low mid-HIGH → all outputs 0 asynchronously; after release, idle until a new `start`.
